// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;
  localparam int DW_DEF = 11;
  localparam int VW_DEF = 6;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [DW_DEF-1:0] DZ_QUOTIENT = '1;

  function automatic logic [DW_DEF-1:0] neg_dw(input logic [DW_DEF-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [VW_DEF-1:0] neg_vw(input logic [VW_DEF-1:0] x);
    return ~x + 1'b1;
  endfunction

  // Magnitude as unsigned; the most-negative value maps onto itself, which is exact unsigned.
  function automatic logic [DW_DEF-1:0] abs_dw(input logic [DW_DEF-1:0] x);
    return x[DW_DEF-1] ? neg_dw(x) : x;
  endfunction

  function automatic logic [VW_DEF-1:0] abs_vw(input logic [VW_DEF-1:0] x);
    return x[VW_DEF-1] ? neg_vw(x) : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int VW = 6
) (
  input  logic [VW-1:0] prem,
  input  logic          bit_in,
  input  logic [VW-1:0] dv,
  output logic [VW-1:0] prem_nx,
  output logic          q_bit
);
  logic [VW:0]   shifted;
  logic [VW-1:0] diff;

  assign shifted = {prem, bit_in};
  // When the subtraction succeeds the result is below |divisor|, so modulo-2^VW is exact.
  assign diff    = shifted[VW-1:0] - dv;
  assign q_bit   = (shifted >= {1'b0, dv});
  assign prem_nx = q_bit ? diff : shifted[VW-1:0];
endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per clock.
module seq_signed_div
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz,
  output logic          ov
);
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  state_t        state, state_nx;
  logic [DW-1:0] dq;
  logic [VW-1:0] prem, prem_nx, mag_dv;
  logic          sign_q, sign_r, q_bit;
  logic [CW-1:0] cnt;
  logic          is_dz, is_ov;

  assign is_dz     = (divisor == '0);
  assign is_ov     = (dividend == MOST_NEG) && (divisor == '1);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_step #(.VW(VW)) u_step (
    .prem    (prem),
    .bit_in  (dq[DW-1]),
    .dv      (mag_dv),
    .prem_nx (prem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (is_dz || is_ov) ? FIX : CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and the shifting {prem, dq} pair; dq turns into the quotient bit by bit.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_q <= dividend[DW-1] ^ divisor[VW-1];
      sign_r <= dividend[DW-1];
      dq     <= abs_dw(dividend);
      mag_dv <= abs_vw(divisor);
      prem   <= '0;
    end else if (state == CALC) begin
      prem <= prem_nx;
      dq   <= {dq[DW-2:0], q_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ov        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt <= CW'(DW-1);
          dz  <= is_dz;
          ov  <= is_ov;
        end
        CALC: cnt <= cnt - 1'b1;
        FIX: begin
          if (dz) begin
            quotient  <= DZ_QUOTIENT;
            remainder <= '0;
          end else if (ov) begin
            quotient  <= MOST_NEG;
            remainder <= '0;
          end else begin
            quotient  <= sign_q ? neg_dw(dq) : dq;
            remainder <= sign_r ? neg_vw(prem) : prem;
          end
        end
        DONE: if (out_ready) begin
          dz <= 1'b0;
          ov <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div against a truncating-division reference model.
module tb_seq_signed_div;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [10:0] dividend, quotient;
  logic [5:0]  divisor, remainder;
  logic        in_ready, out_valid, dz, ov;
  int          nchk = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  seq_signed_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ov        (ov)
  );

  // Reference: C-style truncating division with the two special cases.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output bit edz, output bit eov);
    edz = 1'b0;
    eov = 1'b0;
    if (b == 0) begin
      q = -1; r = 0; edz = 1'b1;
    end else if (a == -1024 && b == -1) begin
      q = -1024; r = 0; eov = 1'b1;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Latency counts clock edges, the acceptance edge being the first; -1 means no result seen.
  task automatic run_op(input int a, input int b, input bit hold, output int lat,
                        output logic [10:0] q_o, output logic [5:0] r_o,
                        output logic dz_o, output logic ov_o);
    int w;
    int t;
    lat = -1; q_o = 'x; r_o = 'x; dz_o = 1'bx; ov_o = 1'bx;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    dividend = a[10:0];
    divisor  = b[5:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 11'($urandom);
    divisor  = 6'($urandom);
    t = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      t++;
      if (out_valid) begin
        lat = t;
        break;
      end
    end
    q_o = quotient; r_o = remainder; dz_o = dz; ov_o = ov;
    if (!hold && lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #3;
    nchk += 6;
    if (in_ready !== 1'b1)    begin nfail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0)   begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (quotient !== 11'd0)   begin nfail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    if (remainder !== 6'd0)   begin nfail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    if (dz !== 1'b0)          begin nfail++; $display("FAIL reset_dz got=%b exp=0", dz); end
    if (ov !== 1'b0)          begin nfail++; $display("FAIL reset_ov got=%b exp=0", ov); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int ta [8] = '{100, -100, 100, 0, -1024, -1024, 1023, -1};
    int tb [8] = '{7, 7, -32, 9, 1, -32, -1, 31};
    int tq [8] = '{14, -14, -3, 0, -1024, 32, -1023, 0};
    int tr [8] = '{2, -2, 4, 0, 0, 0, 0, -1};
    int lat;
    logic [10:0] q, eq;
    logic [5:0] r, er;
    logic fz, fo;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat, q, r, fz, fo);
      eq = tq[i][10:0];
      er = tr[i][5:0];
      nchk += 5;
      if (q !== eq)  begin nfail++; $display("FAIL directed_q %0d/%0d got=%h exp=%h", ta[i], tb[i], q, eq); end
      if (r !== er)  begin nfail++; $display("FAIL directed_r %0d/%0d got=%h exp=%h", ta[i], tb[i], r, er); end
      if (fz !== 1'b0) begin nfail++; $display("FAIL directed_dz %0d/%0d got=%b exp=0", ta[i], tb[i], fz); end
      if (fo !== 1'b0) begin nfail++; $display("FAIL directed_ov %0d/%0d got=%b exp=0", ta[i], tb[i], fo); end
      if (lat != 13) begin nfail++; $display("FAIL directed_latency %0d/%0d got=%0d exp=13", ta[i], tb[i], lat); end
    end
  endtask

  task automatic test_special();
    int ta [3] = '{5, -1024, -1024};
    int tb [3] = '{0, -1, 0};
    bit tz [3] = '{1'b1, 1'b0, 1'b1};
    int tq [3] = '{-1, -1024, -1};
    int lat;
    logic [10:0] q, eq;
    logic [5:0] r;
    logic fz, fo;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat, q, r, fz, fo);
      eq = tq[i][10:0];
      nchk += 7;
      if (q !== eq)      begin nfail++; $display("FAIL special_q %0d/%0d got=%h exp=%h", ta[i], tb[i], q, eq); end
      if (r !== 6'd0)    begin nfail++; $display("FAIL special_r %0d/%0d got=%h exp=0", ta[i], tb[i], r); end
      if (fz !== tz[i])  begin nfail++; $display("FAIL special_dz %0d/%0d got=%b exp=%b", ta[i], tb[i], fz, tz[i]); end
      if (fo !== !tz[i]) begin nfail++; $display("FAIL special_ov %0d/%0d got=%b exp=%b", ta[i], tb[i], fo, !tz[i]); end
      if (lat != 2)      begin nfail++; $display("FAIL special_latency %0d/%0d got=%0d exp=2", ta[i], tb[i], lat); end
      if (dz !== 1'b0)   begin nfail++; $display("FAIL special_dz_clear got=%b exp=0", dz); end
      if (ov !== 1'b0)   begin nfail++; $display("FAIL special_ov_clear got=%b exp=0", ov); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [10:0] q;
    logic [5:0] r;
    logic fz, fo;
    run_op(100, 7, 1'b1, lat, q, r, fz, fo);
    nchk += 1;
    if (lat != 13) begin nfail++; $display("FAIL bp_latency got=%0d exp=13", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; dividend = 11'd50; divisor = 6'd5;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      nchk += 4;
      if (out_valid !== 1'b1)   begin nfail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      if (in_ready !== 1'b0)    begin nfail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      if (quotient !== 11'd14)  begin nfail++; $display("FAIL bp_quotient cyc=%0d got=%h exp=00e", i, quotient); end
      if (remainder !== 6'd2)   begin nfail++; $display("FAIL bp_remainder cyc=%0d got=%h exp=02", i, remainder); end
    end
    // Offer a new operation in the handoff cycle; it must not be taken.
    in_valid = 1'b1; dividend = 11'd77; divisor = 6'd7; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    nchk += 2;
    if (out_valid !== 1'b0) begin nfail++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1)  begin nfail++; $display("FAIL bp_handoff_accept got in_ready=%b exp=1", in_ready); end
    run_op(-77, 7, 1'b0, lat, q, r, fz, fo);
    nchk += 3;
    if (q !== 11'h7f5) begin nfail++; $display("FAIL bp_next_q got=%h exp=7f5", q); end
    if (r !== 6'd0)    begin nfail++; $display("FAIL bp_next_r got=%h exp=00", r); end
    if (lat != 13)     begin nfail++; $display("FAIL bp_next_latency got=%0d exp=13", lat); end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic [10:0] q;
    logic [5:0] r;
    logic fz, fo;
    @(negedge clk);
    in_valid = 1'b1; dividend = 11'd1000; divisor = 6'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nchk += 6;
    if (in_ready !== 1'b1)  begin nfail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    if (quotient !== 11'd0) begin nfail++; $display("FAIL midrst_quotient got=%h exp=0", quotient); end
    if (remainder !== 6'd0) begin nfail++; $display("FAIL midrst_remainder got=%h exp=0", remainder); end
    if (dz !== 1'b0)        begin nfail++; $display("FAIL midrst_dz got=%b exp=0", dz); end
    if (ov !== 1'b0)        begin nfail++; $display("FAIL midrst_ov got=%b exp=0", ov); end
    repeat (20) begin
      @(posedge clk);
      #1;
      nchk += 1;
      if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_held_out_valid got=%b exp=0", out_valid); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(50, 5, 1'b0, lat, q, r, fz, fo);
    nchk += 3;
    if (q !== 11'd10) begin nfail++; $display("FAIL midrst_after_q got=%h exp=00a", q); end
    if (r !== 6'd0)   begin nfail++; $display("FAIL midrst_after_r got=%h exp=00", r); end
    if (lat != 13)    begin nfail++; $display("FAIL midrst_after_latency got=%0d exp=13", lat); end
  endtask

  task automatic test_round_trip();
    int lat;
    int p;
    logic [10:0] q, ea;
    logic [5:0] r;
    logic fz, fo;
    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        if (b == 0 || (a == -32 && b == -32)) continue;
        p = a * b;
        run_op(p, b, 1'b0, lat, q, r, fz, fo);
        ea = a[10:0];
        nchk += 3;
        if (q !== ea)   begin nfail++; $display("FAIL roundtrip_q a=%0d b=%0d got=%h exp=%h", a, b, q, ea); end
        if (r !== 6'd0) begin nfail++; $display("FAIL roundtrip_r a=%0d b=%0d got=%h exp=00", a, b, r); end
        if (lat != 13)  begin nfail++; $display("FAIL roundtrip_latency a=%0d b=%0d got=%0d exp=13", a, b, lat); end
      end
    end
  endtask

  task automatic test_random();
    int a, b, eq_i, er_i, lat, elat;
    bit edz, eov;
    logic [10:0] q, eq;
    logic [5:0] r, er;
    logic fz, fo;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 2047)) - 1024;
      b = int'($urandom_range(0, 63)) - 32;
      if (i % 50 == 7) b = 0;
      if (i % 50 == 13) begin a = -1024; b = -1; end
      model(a, b, eq_i, er_i, edz, eov);
      elat = (edz || eov) ? 2 : 13;
      eq = eq_i[10:0];
      er = er_i[5:0];
      run_op(a, b, 1'b0, lat, q, r, fz, fo);
      nchk += 5;
      if (q !== eq)    begin nfail++; $display("FAIL random_q %0d/%0d got=%h exp=%h", a, b, q, eq); end
      if (r !== er)    begin nfail++; $display("FAIL random_r %0d/%0d got=%h exp=%h", a, b, r, er); end
      if (fz !== edz)  begin nfail++; $display("FAIL random_dz %0d/%0d got=%b exp=%b", a, b, fz, edz); end
      if (fo !== eov)  begin nfail++; $display("FAIL random_ov %0d/%0d got=%b exp=%b", a, b, fo, eov); end
      if (lat != elat) begin nfail++; $display("FAIL random_latency %0d/%0d got=%0d exp=%0d", a, b, lat, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_backpressure();
    test_reset_mid_calc();
    test_round_trip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
